// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter for the UART TX FIFO write port.
// A requester owns the port from its first beat through req_last. A watchdog releases an owner that goes silent mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_REQ),
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_fifo_full,
  output logic                          tx_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         tx_fifo_wr_data,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic                          timeout_event
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             timeout_q, timeout_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  own_valid;
  logic                  own_last;
  logic                  win_found;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       cand;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];

  // Scan starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = rr_ptr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
      cand = next_id(cand);
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    idle_cnt_d      = idle_cnt_q;
    timeout_d       = 1'b0;
    req_ready       = '0;
    tx_fifo_wr_en   = 1'b0;
    tx_fifo_wr_data = '0;

    case (state_q)
      IDLE: begin
        if (uart_en && win_found) begin
          state_d    = LOCKED;
          owner_d    = win_id;
          idle_cnt_d = '0;
        end
      end

      LOCKED: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (owner_q == ID_W'(i)) && !tx_fifo_full;
        end
        tx_fifo_wr_en   = own_valid && !tx_fifo_full;
        tx_fifo_wr_data = data_arr[owner_q];

        if (tx_fifo_wr_en) begin
          if (own_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_id(owner_q);
          end
          idle_cnt_d = '0;
        end else if (!own_valid) begin
          // Owner silent: count toward the watchdog. A full FIFO alone never counts.
          if (idle_cnt_q == IDLE_LIMIT) begin
            state_d    = IDLE;
            rr_ptr_d   = next_id(owner_q);
            idle_cnt_d = '0;
            timeout_d  = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_valid   = (state_q == LOCKED);
  assign grant_id      = owner_q;
  assign timeout_event = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: fairness, no-interleave, backpressure, watchdog, enable and async reset.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            uart_en = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            tx_fifo_full = 1'b0;
  logic            tx_fifo_wr_en;
  logic [DW-1:0]   tx_fifo_wr_data;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            timeout_event;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_en(uart_en),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_fifo_full(tx_fifo_full),
    .tx_fifo_wr_en(tx_fifo_wr_en),
    .tx_fifo_wr_data(tx_fifo_wr_data),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout_event(timeout_event)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int to_pulses = 0;

  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];

  logic         smp_gv, smp_to, smp_wr;
  logic [1:0]   smp_gid;
  logic [DW-1:0] smp_wd;
  logic [N-1:0] smp_rdy;
  logic [N-1:0] acc;

  int         s_len[N];
  logic [7:0] s_base[N];
  int         s_beat[N];
  bit         s_on[N];
  bit         s_rep[N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are set 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step();
    #3;
    smp_gv  = grant_valid;
    smp_gid = grant_id;
    smp_to  = timeout_event;
    smp_wr  = tx_fifo_wr_en;
    smp_wd  = tx_fifo_wr_data;
    smp_rdy = req_ready;
    acc     = req_valid & req_ready;
    if (tx_fifo_wr_en) begin
      got_q.push_back(tx_fifo_wr_data);
      got_cyc.push_back(cyc);
      $display("cycle %0d: fifo write 0x%02h from requester %0d", cyc, tx_fifo_wr_data, grant_id);
    end
    if (timeout_event) begin
      to_pulses++;
      $display("cycle %0d: timeout release", cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic src_cycle();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = s_on[i];
      req_last[i]         = s_on[i] && (s_beat[i] == s_len[i] - 1);
      req_data[i*DW +: DW] = s_on[i] ? s_base[i] + 8'(s_beat[i]) : 8'h00;
    end
    step();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        s_beat[i]++;
        if (s_beat[i] == s_len[i]) begin
          s_beat[i] = 0;
          if (!s_rep[i]) s_on[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    uart_en      = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    tx_fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_on[i] = 1'b0; s_rep[i] = 1'b0; s_beat[i] = 0; s_len[i] = 1; s_base[i] = 8'h00;
    end
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    to_pulses = 0;
    cyc = 0;
  endtask

  task automatic check_got(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size()) check_eq(tag, got_q[k], exp_q[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests present to show nothing leaks through.
    uart_en   = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    @(posedge clock);
    #1;
    @(posedge clock);
    #3;
    check_eq("rst_grant_valid", grant_valid, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_wr_en", tx_fifo_wr_en, 0);
    check_eq("rst_wr_data", tx_fifo_wr_data, 0);
    check_eq("rst_timeout", timeout_event, 0);
    @(posedge clock);
    #1;

    // Fairness: requesters 0 and 2 stream 3-beat packets back to back.
    do_reset();
    uart_en = 1'b1;
    s_on[0] = 1; s_rep[0] = 1; s_len[0] = 3; s_base[0] = 8'hA0;
    s_on[2] = 1; s_rep[2] = 1; s_len[2] = 3; s_base[2] = 8'hC0;
    repeat (16) src_cycle();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 3; b++) exp_q.push_back(8'hA0 + 8'(b));
      for (int b = 0; b < 3; b++) exp_q.push_back(8'hC0 + 8'(b));
    end
    check_got("t1_data");
    for (int k = 0; k + 1 < got_cyc.size(); k++) begin
      check_eq("t1_gap", got_cyc[k+1] - got_cyc[k], (k % 3 == 2) ? 2 : 1);
    end

    // No interleave: requester 3 arrives while requester 1 is mid-packet.
    do_reset();
    uart_en = 1'b1;
    s_on[1] = 1; s_len[1] = 3; s_base[1] = 8'h11;
    s_len[3] = 2; s_base[3] = 8'h31;
    src_cycle();
    src_cycle();
    s_on[3] = 1;
    repeat (2) begin
      src_cycle();
      check_eq("t2_ready3", smp_rdy[3], 0);
      check_eq("t2_ready1", smp_rdy[1], 1);
    end
    repeat (5) src_cycle();
    exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    check_got("t2_data");
    if (got_cyc.size() >= 4) check_eq("t2_bubble", got_cyc[3] - got_cyc[2], 2);

    // Backpressure: FIFO full for 5 cycles, longer than the watchdog limit.
    do_reset();
    uart_en = 1'b1;
    s_on[0] = 1; s_len[0] = 4; s_base[0] = 8'h50;
    repeat (3) src_cycle();
    tx_fifo_full = 1'b1;
    repeat (5) begin
      src_cycle();
      check_eq("t3_stall_wr", smp_wr, 0);
      check_eq("t3_stall_ready", smp_rdy[0], 0);
    end
    check_eq("t3_count_after_stall", got_q.size(), 2);
    tx_fifo_full = 1'b0;
    repeat (4) src_cycle();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'h50 + 8'(b));
    check_got("t3_data");
    check_eq("t3_no_timeout", to_pulses, 0);

    // Watchdog: owner 0 sends one beat then goes silent; requester 1 waits.
    do_reset();
    uart_en   = 1'b1;
    req_data  = 32'h0000_8070;
    req_last  = 4'b0010;
    req_valid = 4'b0011;
    step();
    step();
    check_eq("t4_first_beat_count", got_q.size(), 1);
    if (got_q.size() >= 1) check_eq("t4_first_beat", got_q[0], 8'h70);
    req_valid[0] = 1'b0;
    step();
    step();
    step();
    check_eq("t4_held_c4", smp_gv, 1);
    step();
    check_eq("t4_held_c5", smp_gv, 1);
    check_eq("t4_no_early_to", smp_to, 0);
    step();
    check_eq("t4_released", smp_gv, 0);
    check_eq("t4_timeout_pulse", smp_to, 1);
    step();
    check_eq("t4_next_grant", smp_gv, 1);
    check_eq("t4_next_id", smp_gid, 1);
    check_eq("t4_pulse_one_cycle", smp_to, 0);
    check_eq("t4_next_wr", smp_wr, 1);
    check_eq("t4_next_data", smp_wd, 8'h80);
    req_valid = '0;
    step();
    step();
    check_eq("t4_pulse_count", to_pulses, 1);

    // Enable gating, then asynchronous reset mid-packet.
    do_reset();
    uart_en   = 1'b0;
    req_data  = 32'hE3E2E1E0;
    req_last  = 4'b0001;
    req_valid = 4'b1111;
    repeat (3) begin
      step();
      check_eq("t5_no_grant", smp_gv, 0);
    end
    check_eq("t5_no_writes", got_q.size(), 0);
    uart_en = 1'b1;
    step();
    check_eq("t5_arb_cycle", smp_gv, 0);
    step();
    check_eq("t5_grant0", smp_gv, 1);
    check_eq("t5_grant0_id", smp_gid, 0);
    check_eq("t5_grant0_data", smp_wd, 8'hE0);
    step();
    check_eq("t5_bubble", smp_gv, 0);
    step();
    check_eq("t5_grant1_id", smp_gid, 1);
    check_eq("t5_grant1_data", smp_wd, 8'hE1);
    check_eq("t5_pre_reset_gv", grant_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("t5_async_gv", grant_valid, 0);
    check_eq("t5_async_gid", grant_id, 0);
    check_eq("t5_async_ready", req_ready, 0);
    check_eq("t5_async_wr_en", tx_fifo_wr_en, 0);
    check_eq("t5_async_wr_data", tx_fifo_wr_data, 0);
    check_eq("t5_async_timeout", timeout_event, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step();
    check_eq("t5_post_arb", smp_gv, 0);
    step();
    check_eq("t5_post_gv", smp_gv, 1);
    check_eq("t5_post_id", smp_gid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the UART transmit FIFO write port among several byte-stream requesters, such as a CPU bus bridge, a DMA engine and a debug monitor. A grant is held for a whole packet, from the first beat to the beat with `req_last`, so bytes from different requesters never interleave on the serial line. The block sits between the requesters and the TX FIFO that feeds `uart_controller`. A watchdog forcibly releases a requester that stalls mid-packet.

## Interface
- `NUM_REQ`, default 4: number of requesters; valid range 2..16.
- `DATA_WIDTH`, default 8: width of one byte or beat.
- `TIMEOUT_CYCLES`, default 1024: number of consecutive owner-idle cycles that forces a release; must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_en`  in  1  gates new grants; a packet already in progress completes regardless.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*DATA_WIDTH  beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`  in  NUM_REQ  marks the final beat of a packet; qualified by `req_valid`.
- `req_ready`  out  NUM_REQ  beat accepted when `req_valid[i] && req_ready[i]`.
- `tx_fifo_full`  in  1  TX FIFO full.
- `tx_fifo_wr_en`  out  1  TX FIFO write strobe.
- `tx_fifo_wr_data`  out  DATA_WIDTH  TX FIFO write data.
- `grant_valid`  out  1  high while a requester owns the FIFO.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner.
- `timeout_event`  out  1  one-cycle pulse on a forced release.

## Operation
The state machine has two states, IDLE and LOCKED. The registers are:
- `owner`
- `rr_ptr`, the highest-priority candidate for the next arbitration
- `idle_cnt`, width $clog2(TIMEOUT_CYCLES+1)

IDLE:
- Arbitrates when `uart_en` is high and any `req_valid` is set.
- The winner is the first set `req_valid` bit scanning `rr_ptr`, `rr_ptr`+1, and so on, wrapping from NUM_REQ-1 to 0.
- On the next edge: `owner` takes the winner, the state goes to LOCKED, and `idle_cnt` clears.
- With `uart_en` low, or no request, the state stays in IDLE.

LOCKED, combinational outputs:
- `req_ready[i]` = (i == `owner`) && !`tx_fifo_full`. It does not depend on `req_valid`. All other `req_ready` bits are 0.
- `tx_fifo_wr_en` = `req_valid[owner]` && !`tx_fifo_full`.
- `tx_fifo_wr_data` = owner's `req_data`. It is don't-care when `wr_en` is 0, but is driven to 0 in IDLE.

LOCKED, sequential behaviour:
- **Beat written with `req_last[owner]`:** next state is IDLE, and `rr_ptr` becomes `owner`+1 (mod NUM_REQ).
- **Beat written without last:** `idle_cnt` clears.
- **`req_valid[owner]` low:** `idle_cnt` increments.
- **`tx_fifo_full` high with `req_valid[owner]` high:** this is a stall. `idle_cnt` holds and does not count toward the timeout.
- **`idle_cnt` reaches TIMEOUT_CYCLES-1 while the owner is still idle:** forced release. The next state is IDLE, `rr_ptr` becomes `owner`+1, and `timeout_event` pulses for one cycle (registered, in the cycle after the release).
- **`uart_en` falling in LOCKED:** ignored until the packet ends or times out.

Other rules:
- `grant_valid` = (state == LOCKED). `grant_id` = `owner`, and holds its last value in IDLE.
- Requesters must hold `req_data`/`req_last` stable while valid and not ready. The arbiter does not check this.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is abandoned, and the FIFO keeps the bytes already written.

## Timing
Reset values, asserted asynchronously:
- state = IDLE
- `owner` = 0, `rr_ptr` = 0, `idle_cnt` = 0
- `grant_valid` = 0, `grant_id` = 0
- `req_ready` = 0, `tx_fifo_wr_en` = 0, `tx_fifo_wr_data` = 0, `timeout_event` = 0

Latencies and throughput:
- **Grant latency:** `req_valid` first seen in IDLE at cycle n gives LOCKED at n+1. The first write can occur at n+1 if the FIFO is not full.
- **Throughput:** one beat per cycle while LOCKED, the owner is valid and the FIFO is not full.
- **Packet turnaround:** last beat at cycle m gives IDLE at m+1 and the next grant at m+2, a one-cycle bubble.
- **Single-beat packet** (`req_last` on the first beat): occupies exactly one LOCKED cycle.
- **Timeout:** owner idle from cycle k gives release at the edge ending cycle k+TIMEOUT_CYCLES-1, and `timeout_event` high during the following cycle.
- **FIFO full in the same cycle as a valid last beat:** no write, no release; the beat is retried.

## Test plan
1. **Fairness.** Stimulus: reset, `uart_en`=1; requesters 0 and 2 each present 3-beat packets (0xA0..A2 and 0xC0..C2) continuously. Required response: FIFO receives A0 A1 A2, then C0 C1 C2, then A0…, alternating, with exactly one bubble cycle between packets.
2. **No interleave.** Stimulus: requester 1 owns the grant for packet 0x11,0x12,0x13; requester 3 raises valid mid-packet. Required response: 0x11..0x13 written contiguously before any requester-3 byte; `req_ready[3]`=0 throughout.
3. **Backpressure.** Stimulus: `tx_fifo_full`=1 for 5 cycles mid-packet, with TIMEOUT_CYCLES=4. Required response: no writes during the stall, no `timeout_event`, and the packet resumes intact.
4. **Timeout.** Stimulus: TIMEOUT_CYCLES=4; the owner sends one beat then drops valid. Required response: release after 4 idle cycles, a single-cycle `timeout_event`, and the next requester granted.
5. **Enable and reset.** Stimulus: `uart_en`=0 with `req_valid`=4'b1111. Required response: no grant. Then raise `uart_en`; requester 0 is granted. Assert `reset` mid-packet: all outputs return to 0 asynchronously, and after reset release requester 0 wins again.
